// File: rtl/fu_divsqrt_q_accum.sv
// SRT radix-2 quotient accumulator: on-the-fly Q/QM conversion, digit count, remainder-sign fix.
// Optional macro FU_DIVSQRT_QACC_PARITY_EN adds the res_par even-parity output.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | consuming quotient digits
// S_FIX  | select Q or QM from the remainder sign
// S_DONE | result presented, waiting for res_rdy

module fu_divsqrt_q_accum #(
   parameter int WIDTH = 56,
   parameter int ITER  = 56,
   parameter int CNT_W = 6
) (
   input  logic             nclk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic             digit_vld,
   input  logic             q_pos,
   input  logic             q_neg,
   input  logic             rem_neg,
   output logic             busy,
   output logic             res_vld,
   input  logic             res_rdy,
   output logic [0:WIDTH-1] res_q,
   output logic             res_err
`ifdef FU_DIVSQRT_QACC_PARITY_EN
   ,
   output logic             res_par
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   state_t           state;
   state_t           state_nxt;
   logic [0:WIDTH-1] q;
   logic [0:WIDTH-1] qm;
   logic [CNT_W-1:0] cnt;
   logic             err;
   logic             d_pos;
   logic             d_neg;
   logic             take;
   logic [0:WIDTH-1] sel_q;

   assign d_pos = q_pos & ~q_neg;
   assign d_neg = q_neg & ~q_pos;
   assign take  = (state == S_RUN) && digit_vld;
   assign sel_q = rem_neg ? qm : q;

   assign busy    = (state != S_IDLE);
   assign res_vld = (state == S_DONE);

   always_ff @(posedge nclk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (digit_vld && (cnt == CNT_LAST)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  if (res_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // QM tracks Q-1, so a -1 digit borrows by switching to QM instead of subtracting.
   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         q       <= '0;
         qm      <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         res_q   <= '0;
         res_err <= 1'b0;
      end else begin
         if ((state == S_IDLE) && start) begin
            q   <= '0;
            qm  <= '1;
            cnt <= '0;
            err <= 1'b0;
         end else if (take) begin
            cnt <= cnt + 1'b1;
            if (d_pos) begin
               q  <= {q[1:WIDTH-1], 1'b1};
               qm <= {q[1:WIDTH-1], 1'b0};
            end else if (d_neg) begin
               q  <= {qm[1:WIDTH-1], 1'b1};
               qm <= {qm[1:WIDTH-1], 1'b0};
            end else begin
               q  <= {q[1:WIDTH-1], 1'b0};
               qm <= {qm[1:WIDTH-1], 1'b1};
            end
            if (q_pos && q_neg) err <= 1'b1;
         end
         if (state == S_FIX) begin
            res_q   <= sel_q;
            res_err <= err;
         end
      end
   end

`ifdef FU_DIVSQRT_QACC_PARITY_EN
   always_ff @(posedge nclk or posedge rst) begin
      if (rst)                 res_par <= 1'b0;
      else if (state == S_FIX) res_par <= ^sel_q;
   end
`endif

endmodule

// File: doc/fu_divsqrt_q_accum.md
Name: fu_divsqrt_q_accum

Overview:
Downstream consumer of the radix-2 SRT quotient-digit selection tables in the divide/sqrt unit. Each iteration it takes one signed quotient digit {-1,0,+1} and updates a Q / QM register pair by on-the-fly conversion, so no carry-propagate add is needed per iteration. It counts digits and applies the final remainder-sign correction. It then presents the quotient to the normalize/round stage with a valid/ready handshake.

Parameters:
WIDTH, 56, quotient width in bits; big-endian [0:WIDTH-1], bit WIDTH-1 is LSB.
ITER, 56, number of digits per operation; must satisfy 1 <= ITER <= WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
nclk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  begin operation; accepted only in IDLE.
flush  in  1  synchronous abort; return to IDLE.
digit_vld  in  1  q_pos/q_neg valid this cycle.
q_pos  in  1  digit +1 (positive-table q output).
q_neg  in  1  digit -1 (negative-table q output).
rem_neg  in  1  final partial remainder sign; sampled in FIX only.
busy  out  1  state != IDLE.
res_vld  out  1  result valid (DONE state).
res_rdy  in  1  consumer accepts the result.
res_q  out  WIDTH  corrected quotient.
res_err  out  1  sticky: illegal digit seen during this operation.

Behaviour:
- States: IDLE, RUN, FIX, DONE. Encoding is free; outputs must be registered or state-decoded only.
- Reset (async): state=IDLE, Q=0, QM=0, cnt=0, err=0, res_q=0. Outputs busy=0, res_vld=0, res_err=0.
- IDLE:
  - start=1 -> RUN; Q=0, QM=all-ones (Q-1 mod 2^WIDTH), cnt=0, err=0.
  - start is ignored in every other state.
- RUN, digit_vld=1: digit d = +1 if q_pos&!q_neg; -1 if q_neg&!q_pos; 0 otherwise. cnt increments.
  - d=+1: Q<=Q<<1|1, QM<=Q<<1|0.
  - d=0: Q<=Q<<1|0, QM<=QM<<1|1.
  - d=-1: Q<=QM<<1|1, QM<=QM<<1|0.
  - q_pos&q_neg: treat as d=0 and set err (sticky until next accepted start).
  - Invariant QM=Q-1 (mod 2^WIDTH) holds after every update. Shifts drop the MSB.
- RUN, digit_vld=0: stall; no register changes, cnt unchanged.
- RUN -> FIX on the cycle the ITER-th digit is consumed (cnt==ITER-1 and digit_vld).
- FIX (one cycle): res_q<=rem_neg ? QM : Q; res_err<=err; -> DONE.
  - Latency: res_vld rises exactly 2 cycles after the last digit edge.
- DONE: res_vld=1, res_q/res_err held stable.
  - res_rdy=1 -> IDLE next cycle.
  - digit_vld is ignored in FIX and DONE.
- ITER<WIDTH: result is right-aligned (the LSB holds the last digit); upper bits are sign-extended by the conversion itself.
- flush=1 in any state -> IDLE next cycle; no res_vld; Q/QM/res_q contents don't-care.
  - flush beats start, digit_vld and res_rdy in the same cycle.
- start together with res_rdy in DONE: start ignored; the bench must re-issue start in IDLE.
- Async reset mid-operation: immediate return to reset values; no partial result is emitted.

Optional Feature:
FU_DIVSQRT_QACC_PARITY_EN
- Defined: adds output res_par (1 bit), the even parity of res_q, computed and registered in FIX alongside res_q. XOR of res_q bits plus res_par = 0. Reset value 0; held in DONE.
- Undefined: port absent; no parity logic.

Test Plan:
1. WIDTH=8, ITER=8; start, then 8 digits +1 back-to-back, rem_neg=0 -> res_vld exactly 2 cycles after the 8th digit, res_q=0xFF, res_err=0; res_rdy=1 -> IDLE, busy=0.
2. Digits +1,0,0,0,0,0,0,-1, rem_neg=1 -> value 127, QM selected: res_q=0x7E. Rerun with rem_neg=0 -> res_q=0x7F; with PARITY_EN, res_par=1.
3. Digits +1 x8 with digit_vld low for 3 cycles between digits 4 and 5 -> cnt holds during gaps; res_q=0xFF; res_vld 2 cycles after the last valid digit.
4. Digit 3 driven with q_pos=q_neg=1, all other digits 0, first digit +1 -> digit 3 treated as 0; res_q=0x80; res_err=1. Next operation after start -> res_err=0.
5. flush after 3 digits, and separately flush in DONE while res_rdy=0 -> IDLE next cycle; res_vld never asserts after flush. A subsequent start gives a correct result from Q=0 / QM=0xFF.
6. Async rst asserted mid-RUN, between clock edges -> busy, res_vld, res_err and res_q go to 0 immediately; start after deassertion operates normally.
